// File: rtl/scoreboard_pkg.sv
// Shared types, default parameters and width constants for the scoreboard controller.
// Saturating score helpers work in SCORE_SUM_W bits so a near-limit add cannot wrap.
package scoreboard_pkg;

  localparam int SCORE_W        = 8;
  localparam int SCORE_SUM_W    = 9;
  localparam int SHOT_W         = 6;
  localparam int SHOT_FULL_DEF  = 24;
  localparam int SHOT_SHORT_DEF = 14;
  localparam int SCORE_MAX_DEF  = 99;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSED,
    ST_EXPIRED
  } state_t;

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] score,
                                                 input logic [1:0]         pts,
                                                 input int                 max_val);
    logic [SCORE_SUM_W-1:0] sum;
    sum = {1'b0, score} + {{(SCORE_SUM_W-2){1'b0}}, pts};
    if (sum > SCORE_SUM_W'(max_val)) begin
      return SCORE_W'(max_val);
    end
    return sum[SCORE_W-1:0];
  endfunction

  function automatic logic [SCORE_W-1:0] sat_sub(input logic [SCORE_W-1:0] score,
                                                 input logic [1:0]         pts);
    logic [SCORE_W-1:0] pts_w;
    pts_w = {{(SCORE_W-2){1'b0}}, pts};
    return (score >= pts_w) ? (score - pts_w) : '0;
  endfunction

endpackage

// File: rtl/shot_clock_counter.sv
// Shot-clock register: full reload, short reload and decrement, in that priority.
// One-edge latency; zero_o flags an empty clock so the caller can stop decrementing.
module shot_clock_counter
  import scoreboard_pkg::*;
#(
  parameter int FULL  = SHOT_FULL_DEF,
  parameter int SHORT = SHOT_SHORT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              load_short_i,
  input  logic              dec_en_i,
  output logic [SHOT_W-1:0] count_o,
  output logic              zero_o
);

  logic [SHOT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = SHOT_W'(FULL);
    end else if (load_short_i) begin
      count_d = SHOT_W'(SHORT);
    end else if (dec_en_i) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= SHOT_W'(FULL);
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/scoreboard_ctrl.sv
// Game scoreboard: play-state FSM, shot clock with horn, saturating team scores.
// Optional last-score undo is built only when SCORE_UNDO_EN is defined.
module scoreboard_ctrl
  import scoreboard_pkg::*;
#(
  parameter int SHOT_FULL  = SHOT_FULL_DEF,
  parameter int SHOT_SHORT = SHOT_SHORT_DEF,
  parameter int SCORE_MAX  = SCORE_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_1hz,
  input  logic               start,
  input  logic               pause,
  input  logic [1:0]         add_a,
  input  logic [1:0]         add_b,
  input  logic               shot_rst,
  input  logic               shot_short,
  input  logic               undo,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic [SHOT_W-1:0]  shot_clock,
  output logic               running,
  output logic               horn
);

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] score_a_q, score_a_d;
  logic [SCORE_W-1:0] score_b_q, score_b_d;
  logic               running_q, horn_q;

  logic active, tick_run, reload, expire, shot_zero;
  logic undo_a, undo_b;
  logic [1:0] undo_pts;

  assign active   = (state_q != ST_IDLE);
  assign tick_run = (state_q == ST_RUN) && tick_1hz;
  assign reload   = active && (shot_rst || shot_short);
  // A reload on the final tick keeps play alive rather than expiring.
  assign expire   = tick_run && (shot_clock == SHOT_W'(1)) && !reload;

  shot_clock_counter #(
    .FULL  (SHOT_FULL),
    .SHORT (SHOT_SHORT)
  ) u_shot (
    .clk          (clk),
    .rst          (rst),
    .load_i       (active && shot_rst),
    .load_short_i (active && shot_short && !shot_rst),
    .dec_en_i     (tick_run && !shot_zero),
    .count_o      (shot_clock),
    .zero_o       (shot_zero)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start && !pause) state_d = ST_RUN;
      ST_RUN: begin
        if (expire)     state_d = ST_EXPIRED;
        else if (pause) state_d = ST_PAUSED;
      end
      ST_PAUSED:  if (start && !pause) state_d = ST_RUN;
      ST_EXPIRED: if (shot_rst || shot_short) state_d = ST_PAUSED;
      default:    state_d = ST_IDLE;
    endcase
  end

`ifdef SCORE_UNDO_EN
  logic       rec_vld_q, rec_vld_d;
  logic       rec_team_q, rec_team_d;  // 0 = Team A, 1 = Team B
  logic [1:0] rec_pts_q, rec_pts_d;

  // An add to the recorded team in the same clk wins; the undo is dropped.
  assign undo_a   = active && undo && rec_vld_q && !rec_team_q && (add_a == 2'd0);
  assign undo_b   = active && undo && rec_vld_q &&  rec_team_q && (add_b == 2'd0);
  assign undo_pts = rec_pts_q;

  always_comb begin
    rec_vld_d  = rec_vld_q;
    rec_team_d = rec_team_q;
    rec_pts_d  = rec_pts_q;
    if (undo_a || undo_b) begin
      rec_vld_d = 1'b0;
    end
    if (active && (add_b != 2'd0)) begin
      rec_vld_d  = 1'b1;
      rec_team_d = 1'b1;
      rec_pts_d  = add_b;
    end else if (active && (add_a != 2'd0)) begin
      rec_vld_d  = 1'b1;
      rec_team_d = 1'b0;
      rec_pts_d  = add_a;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rec_vld_q  <= 1'b0;
      rec_team_q <= 1'b0;
      rec_pts_q  <= 2'd0;
    end else begin
      rec_vld_q  <= rec_vld_d;
      rec_team_q <= rec_team_d;
      rec_pts_q  <= rec_pts_d;
    end
  end
`else
  logic unused_undo;
  assign unused_undo = undo;
  assign undo_a      = 1'b0;
  assign undo_b      = 1'b0;
  assign undo_pts    = 2'd0;
`endif

  always_comb begin
    score_a_d = score_a_q;
    score_b_d = score_b_q;
    if (active && (add_a != 2'd0)) begin
      score_a_d = sat_add(score_a_q, add_a, SCORE_MAX);
    end else if (undo_a) begin
      score_a_d = sat_sub(score_a_q, undo_pts);
    end
    if (active && (add_b != 2'd0)) begin
      score_b_d = sat_add(score_b_q, add_b, SCORE_MAX);
    end else if (undo_b) begin
      score_b_d = sat_sub(score_b_q, undo_pts);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      score_a_q <= '0;
      score_b_q <= '0;
      running_q <= 1'b0;
      horn_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      score_a_q <= score_a_d;
      score_b_q <= score_b_d;
      running_q <= (state_d == ST_RUN);
      horn_q    <= expire;
    end
  end

  assign score_a = score_a_q;
  assign score_b = score_b_q;
  assign running = running_q;
  assign horn    = horn_q;

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Directed bench for scoreboard_ctrl: FSM, shot clock, horn, saturation, undo, async reset.
// Undo expectations follow whether SCORE_UNDO_EN is defined for this build.
module tb_scoreboard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0, start = 1'b0, pause = 1'b0;
  logic [1:0] add_a = 2'd0, add_b = 2'd0;
  logic       shot_rst = 1'b0, shot_short = 1'b0, undo = 1'b0;
  logic [7:0] score_a, score_b;
  logic [5:0] shot_clock;
  logic       running, horn;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  scoreboard_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .tick_1hz   (tick_1hz),
    .start      (start),
    .pause      (pause),
    .add_a      (add_a),
    .add_b      (add_b),
    .shot_rst   (shot_rst),
    .shot_short (shot_short),
    .undo       (undo),
    .score_a    (score_a),
    .score_b    (score_b),
    .shot_clock (shot_clock),
    .running    (running),
    .horn       (horn)
  );

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    tick_1hz = 0; start = 0; pause = 0; add_a = 0; add_b = 0;
    shot_rst = 0; shot_short = 0; undo = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    #1;
    n_checks++; if (score_a !== 8'd0) begin n_fail++; $display("FAIL reset_score_a got=%0d want=0", score_a); end
    n_checks++; if (score_b !== 8'd0) begin n_fail++; $display("FAIL reset_score_b got=%0d want=0", score_b); end
    n_checks++; if (shot_clock !== 6'd24) begin n_fail++; $display("FAIL reset_shot got=%0d want=24", shot_clock); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running got=%0b want=0", running); end
    n_checks++; if (horn !== 1'b0) begin n_fail++; $display("FAIL reset_horn got=%0b want=0", horn); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_idle_ignored();
    add_a = 2'd3; shot_short = 1; tick_1hz = 1; pause = 1;
    step();
    clear_inputs();
    n_checks++; if (score_a !== 8'd0) begin n_fail++; $display("FAIL idle_add got=%0d want=0", score_a); end
    n_checks++; if (shot_clock !== 6'd24) begin n_fail++; $display("FAIL idle_shot got=%0d want=24", shot_clock); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL idle_running got=%0b want=0", running); end
  endtask

  task automatic test_expire();
    start = 1; step(); clear_inputs();
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL start_running got=%0b want=1", running); end
    for (int i = 1; i <= 24; i++) begin
      tick_1hz = 1; step(); clear_inputs();
      n_checks++; if (shot_clock !== 6'(24 - i)) begin n_fail++; $display("FAIL tick_shot i=%0d got=%0d want=%0d", i, shot_clock, 24 - i); end
      n_checks++; if (horn !== (i == 24)) begin n_fail++; $display("FAIL tick_horn i=%0d got=%0b want=%0b", i, horn, (i == 24)); end
    end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL expired_running got=%0b want=0", running); end
    tick_1hz = 1; start = 1; step(); clear_inputs();
    n_checks++; if (horn !== 1'b0) begin n_fail++; $display("FAIL horn_single got=%0b want=0", horn); end
    n_checks++; if (shot_clock !== 6'd0) begin n_fail++; $display("FAIL expired_tick got=%0d want=0", shot_clock); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL expired_start got=%0b want=0", running); end
    shot_rst = 1; step(); clear_inputs();
    n_checks++; if (shot_clock !== 6'd24) begin n_fail++; $display("FAIL expired_reload got=%0d want=24", shot_clock); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL reload_paused got=%0b want=0", running); end
    start = 1; step(); clear_inputs();
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL resume_running got=%0b want=1", running); end
  endtask

  task automatic test_shot_short();
    for (int i = 0; i < 14; i++) begin
      tick_1hz = 1; step(); clear_inputs();
    end
    n_checks++; if (shot_clock !== 6'd10) begin n_fail++; $display("FAIL run_to_10 got=%0d want=10", shot_clock); end
    tick_1hz = 1; shot_short = 1; step(); clear_inputs();
    n_checks++; if (shot_clock !== 6'd14) begin n_fail++; $display("FAIL short_over_tick got=%0d want=14", shot_clock); end
    tick_1hz = 1; shot_short = 1; shot_rst = 1; step(); clear_inputs();
    n_checks++; if (shot_clock !== 6'd24) begin n_fail++; $display("FAIL rst_over_short got=%0d want=24", shot_clock); end
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL still_running got=%0b want=1", running); end
  endtask

  task automatic test_paused();
    pause = 1; step(); clear_inputs();
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL pause_running got=%0b want=0", running); end
    for (int i = 0; i < 5; i++) begin
      tick_1hz = 1; step(); clear_inputs();
    end
    n_checks++; if (shot_clock !== 6'd24) begin n_fail++; $display("FAIL paused_ticks got=%0d want=24", shot_clock); end
    start = 1; pause = 1; step(); clear_inputs();
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL start_pause_same got=%0b want=0", running); end
    shot_short = 1; step(); clear_inputs();
    n_checks++; if (shot_clock !== 6'd14) begin n_fail++; $display("FAIL paused_short got=%0d want=14", shot_clock); end
    start = 1; step(); clear_inputs();
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL paused_resume got=%0b want=1", running); end
  endtask

  task automatic test_score_sat();
    for (int i = 0; i < 32; i++) begin
      add_a = 2'd3; step(); clear_inputs();
    end
    n_checks++; if (score_a !== 8'd96) begin n_fail++; $display("FAIL score_96 got=%0d want=96", score_a); end
    add_a = 2'd1; step(); clear_inputs();
    add_a = 2'd3; step(); clear_inputs();
    n_checks++; if (score_a !== 8'd99) begin n_fail++; $display("FAIL score_97p3 got=%0d want=99", score_a); end
    add_a = 2'd1; step(); clear_inputs();
    n_checks++; if (score_a !== 8'd99) begin n_fail++; $display("FAIL score_hold got=%0d want=99", score_a); end
    add_a = 2'd2; add_b = 2'd3; step(); clear_inputs();
    n_checks++; if (score_b !== 8'd3) begin n_fail++; $display("FAIL dual_add_b got=%0d want=3", score_b); end
    n_checks++; if (score_a !== 8'd99) begin n_fail++; $display("FAIL dual_add_a got=%0d want=99", score_a); end
  endtask

  task automatic test_undo();
    logic [7:0] want_u1, want_coinc;
`ifdef SCORE_UNDO_EN
    want_u1 = 8'd5; want_coinc = 8'd8;
`else
    want_u1 = 8'd7; want_coinc = 8'd10;
`endif
    add_b = 2'd2; step(); clear_inputs();
    n_checks++; if (score_b !== 8'd5) begin n_fail++; $display("FAIL undo_pre got=%0d want=5", score_b); end
    add_b = 2'd2; step(); clear_inputs();
    n_checks++; if (score_b !== 8'd7) begin n_fail++; $display("FAIL undo_add got=%0d want=7", score_b); end
    undo = 1; step(); clear_inputs();
    n_checks++; if (score_b !== want_u1) begin n_fail++; $display("FAIL undo_first got=%0d want=%0d", score_b, want_u1); end
    undo = 1; step(); clear_inputs();
    n_checks++; if (score_b !== want_u1) begin n_fail++; $display("FAIL undo_second got=%0d want=%0d", score_b, want_u1); end
    add_b = 2'd1; step(); clear_inputs();
    add_b = 2'd2; undo = 1; step(); clear_inputs();
    n_checks++; if (score_b !== want_coinc) begin n_fail++; $display("FAIL undo_vs_add got=%0d want=%0d", score_b, want_coinc); end
  endtask

  task automatic test_async_reset();
    do_reset();
    start = 1; step(); clear_inputs();
    for (int i = 0; i < 13; i++) begin
      add_a = 2'd3; step(); clear_inputs();
    end
    add_a = 2'd1; step(); clear_inputs();
    tick_1hz = 1; step(); clear_inputs();
    n_checks++; if (score_a !== 8'd40) begin n_fail++; $display("FAIL pre_rst_score got=%0d want=40", score_a); end
    n_checks++; if (shot_clock !== 6'd23) begin n_fail++; $display("FAIL pre_rst_shot got=%0d want=23", shot_clock); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (score_a !== 8'd0) begin n_fail++; $display("FAIL async_score got=%0d want=0", score_a); end
    n_checks++; if (shot_clock !== 6'd24) begin n_fail++; $display("FAIL async_shot got=%0d want=24", shot_clock); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL async_running got=%0b want=0", running); end
    start = 1; add_a = 2'd3;
    step();
    rst = 1'b0;
    step(); clear_inputs();
    n_checks++; if (score_a !== 8'd0) begin n_fail++; $display("FAIL post_rst_add got=%0d want=0", score_a); end
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL post_rst_start got=%0b want=1", running); end
  endtask

  initial begin
    test_reset();
    test_idle_ignored();
    test_expire();
    test_shot_short();
    test_paused();
    test_score_sat();
    test_undo();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scoreboard_ctrl.md
SCOREBOARD_CTRL -- requirements
Module: scoreboard_ctrl

Interface
REQ-001 Parameter SHOT_FULL, default 24: shot-clock reload value, in seconds.
REQ-002 Parameter SHOT_SHORT, default 14: shot-clock short-reload value, in seconds.
REQ-003 Parameter SCORE_MAX, default 99: saturation limit for each team score.
REQ-004 clk  input  1  system clock, single clock domain.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 tick_1hz  input  1  one-clk-wide strobe, once per second.
REQ-007 start  input  1  one-clk pulse: begin or resume play.
REQ-008 pause  input  1  one-clk pulse: stop play.
REQ-009 add_a  input  2  points to add to Team A (0 = none, 1–3), sampled every clk.
REQ-010 add_b  input  2  points to add to Team B (0 = none, 1–3), sampled every clk.
REQ-011 shot_rst  input  1  one-clk pulse: reload shot clock with SHOT_FULL.
REQ-012 shot_short  input  1  one-clk pulse: reload shot clock with SHOT_SHORT.
REQ-013 undo  input  1  one-clk pulse: revert the last score event (only when SCORE_UNDO_EN is defined).
REQ-014 score_a  output  8  Team A score, binary, 0..SCORE_MAX.
REQ-015 score_b  output  8  Team B score, binary, 0..SCORE_MAX.
REQ-016 shot_clock  output  6  shot-clock seconds remaining, binary.
REQ-017 running  output  1  high while in state RUN.
REQ-018 horn  output  1  one-clk pulse when the shot clock expires.

Function
REQ-019 FSM states: IDLE, RUN, PAUSED, EXPIRED; all outputs registered.
- IDLE→RUN on start; RUN→PAUSED on pause; PAUSED→RUN on start.
- RUN→EXPIRED when shot_clock is 1 and tick_1hz is high.
- EXPIRED→PAUSED on shot_rst or shot_short (reload applied in the same clk).
REQ-020 In RUN, each tick_1hz decrements shot_clock by 1; ticks in any other state are ignored.
REQ-021 On the RUN→EXPIRED transition: shot_clock becomes 0, and horn pulses high for exactly one clk in the same edge.
REQ-022 shot_rst/shot_short take effect on the next edge in any state except IDLE, and override a coincident decrement.
REQ-023 shot_rst has priority over shot_short when both are asserted.
REQ-024 Score update: score <= min(score + add, SCORE_MAX), one-clk latency, accepted in every state except IDLE.
REQ-025 add_a and add_b asserted in the same clk are both applied.
REQ-026 start and pause asserted in the same clk: pause wins.
REQ-027 start in RUN or EXPIRED is ignored; pause in IDLE, PAUSED or EXPIRED is ignored.
REQ-028 Internal arithmetic uses 9 bits before saturation, so no wrap-around occurs at 8 bits.

Reset
REQ-029 rst asynchronously forces: state=IDLE, score_a=0, score_b=0, shot_clock=SHOT_FULL, running=0, horn=0, undo record cleared.
REQ-030 rst asserted mid-game discards all in-flight pulses; the first edge after deassertion behaves as IDLE.

Configuration
REQ-031 Macro SCORE_UNDO_EN defined: the block records the last non-zero score event (team, points).
- undo subtracts the recorded points from that team, floored at 0, one-clk latency, then clears the record.
- undo with an empty record is a no-op.
- undo coincident with an add to the same team: add wins and undo is dropped.
REQ-032 Macro SCORE_UNDO_EN not defined: the undo port exists but is ignored, and no record registers are synthesized.

Structure
REQ-033 Package scoreboard_pkg holds the FSM state enum, SHOT_FULL/SHOT_SHORT/SCORE_MAX defaults and the score/shot width constants.
REQ-034 One sub-module, shot_clock_counter (load, short-load, decrement-enable, zero flag), is instantiated once; score logic stays inline.

Verification
REQ-035 rst, then start, then 24 ticks → shot_clock steps 24→0, horn pulses once on the 24th tick, state=EXPIRED, running=0.
REQ-036 Score 97, add_a=3 → score_a=99; a further add_a=1 → score_a stays 99.
REQ-037 RUN with shot_clock=10, tick and shot_short in the same clk → shot_clock=14 (not 9).
REQ-038 PAUSED: 5 ticks → shot_clock unchanged; start and pause in the same clk → remains PAUSED.
REQ-039 SCORE_UNDO_EN defined: add_b=2 (score_b 5→7), undo → score_b=5; a second undo → score_b stays 5.
REQ-040 rst pulse mid-RUN with score_a=40 → score_a=0, shot_clock=24, state=IDLE asynchronously, without waiting for a clk edge.
